// File: rtl/pixel_gearbox_pkg.sv
// pixel_gearbox_pkg: pixel group geometry and fetch state encoding shared by the reader and writer gearboxes
package pixel_gearbox_pkg;
  localparam int INPUT_DATA_SIZE = 24;
  localparam int PIXELS_PER_GROUP = 64;
  localparam int BEATS_PER_GROUP = 3;
  localparam int GROUP_BITS = 1536;
  localparam int BEAT_BITS = GROUP_BITS / BEATS_PER_GROUP;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL_DONE} fetch_state_e;
endpackage

// File: rtl/pixel_group_unpacker.sv
// pixel_group_unpacker: ping-pong group buffers, full flags and 24-bit pixel slicing onto a valid/ready stream
module pixel_group_unpacker
  import pixel_gearbox_pkg::*;
(
  input  logic                       m_axi_aclk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_slot,
  input  logic [BEAT_BITS-1:0]       wr_data,
  output logic                       wr_full,
  input  logic                       last_pix,
  input  logic                       pix_ready,
  output logic [INPUT_DATA_SIZE-1:0] pix_data,
  output logic                       pix_valid,
  output logic                       pix_last,
  output logic                       pix_fire
);
  localparam int IW = $clog2(PIXELS_PER_GROUP);
  logic [GROUP_BITS-1:0] buf_q [2];
  logic [GROUP_BITS-1:0] buf_d [2];
  logic [1:0] full_q, full_d;
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic fill, drain;
  assign fill = wr_en && wr_slot == 2'(BEATS_PER_GROUP - 1);
  assign wr_full = full_q[wr_ptr_q];
  assign pix_valid = full_q[rd_ptr_q];
  assign pix_data = pix_valid ? buf_q[rd_ptr_q][INPUT_DATA_SIZE*idx_q +: INPUT_DATA_SIZE] : '0;
  assign pix_last = pix_valid && last_pix;
  assign pix_fire = pix_valid && pix_ready;
  assign drain = pix_fire && (last_pix || idx_q == IW'(PIXELS_PER_GROUP - 1));
  assign wr_ptr_d = fill ? ~wr_ptr_q : wr_ptr_q;
  assign rd_ptr_d = drain ? ~rd_ptr_q : rd_ptr_q;
  assign idx_d = drain ? '0 : pix_fire ? idx_q + 1'b1 : idx_q;
  always_comb begin
    buf_d = buf_q;
    full_d = full_q;
    if (wr_en) buf_d[wr_ptr_q][BEAT_BITS*wr_slot +: BEAT_BITS] = wr_data;
    if (fill) full_d[wr_ptr_q] = 1'b1;
    if (drain) full_d[rd_ptr_q] = 1'b0;
  end
  always_ff @(posedge m_axi_aclk) buf_q <= buf_d;
  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      full_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      idx_q <= '0;
    end else begin
      full_q <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/dram_pixel_unpacker.sv
// dram_pixel_unpacker: fetch packed 3-beat pixel groups from DRAM and stream 24-bit pixels; DRAM_PIXEL_UNPACKER_FRAME_LOOP_EN repeats frames
module dram_pixel_unpacker
  import pixel_gearbox_pkg::*;
#(
  parameter int                         DRAM_ADDR_WIDTH = 39,
  parameter logic [DRAM_ADDR_WIDTH-1:0] DRAM_ADDR_BASE  = 39'h400000000,
  parameter int                         DRAM_DATA_WIDTH = 512,
  parameter int                         ADDR_STEP       = 64,
  parameter int                         FRAME_LEN_WIDTH = 24
)(
  input  logic                       m_axi_aclk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [FRAME_LEN_WIDTH-1:0] frame_len,
  output logic                       busy,
  output logic                       done,
  output logic                       dram_read_en,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  output logic [7:0]                 dram_read_len,
  input  logic                       dram_read_busy,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  input  logic                       dram_read_valid,
  output logic [23:0]                pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_last
);
  localparam int GW = FRAME_LEN_WIDTH - 5;
  function automatic logic [GW-1:0] groups_of(input logic [FRAME_LEN_WIDTH-1:0] n);
    return {1'b0, n[FRAME_LEN_WIDTH-1:6]} + GW'(|n[5:0]);
  endfunction
  fetch_state_e state_q, state_d;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0] beat_q, beat_d;
  logic [GW-1:0] groups_q, groups_d;
  logic [FRAME_LEN_WIDTH-1:0] pixels_q, pixels_d;
  logic busy_q, busy_d, done_q, done_d, en_q, en_d;
  logic wr_en, wr_full, beat_last, pix_fire;
`ifdef DRAM_PIXEL_UNPACKER_FRAME_LOOP_EN
  logic [FRAME_LEN_WIDTH-1:0] len_q, len_d;
`endif
  assign wr_en = state_q == WAIT && dram_read_valid;
  assign beat_last = beat_q == 2'(BEATS_PER_GROUP - 1);
  assign busy = busy_q;
  assign done = done_q;
  assign dram_read_en = en_q;
  assign dram_read_addr = addr_q;
  assign dram_read_len = 8'h0;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    beat_d = beat_q;
    groups_d = groups_q;
    pixels_d = pixels_q;
    busy_d = busy_q;
    done_d = 1'b0;
    en_d = 1'b0;
`ifdef DRAM_PIXEL_UNPACKER_FRAME_LOOP_EN
    len_d = len_q;
`endif
    if (start && !busy_q) begin
      busy_d = frame_len != '0;
      done_d = frame_len == '0;
      state_d = frame_len != '0 ? REQ : IDLE;
      addr_d = DRAM_ADDR_BASE;
      beat_d = '0;
      groups_d = groups_of(frame_len);
      pixels_d = frame_len;
`ifdef DRAM_PIXEL_UNPACKER_FRAME_LOOP_EN
      len_d = frame_len;
`endif
    end
    if (state_q == REQ && !dram_read_busy && !wr_full) begin
      en_d = 1'b1;
      state_d = WAIT;
    end
    if (wr_en) begin
      addr_d = addr_q + DRAM_ADDR_WIDTH'(ADDR_STEP);
      beat_d = beat_last ? '0 : beat_q + 1'b1;
      state_d = beat_last ? FILL_DONE : REQ;
    end
    if (state_q == FILL_DONE) begin
      groups_d = groups_q - 1'b1;
      state_d = groups_q == GW'(1) ? IDLE : REQ;
    end
    if (pix_fire) pixels_d = pixels_q - 1'b1;
    if (pix_fire && pix_last) begin
      done_d = 1'b1;
`ifdef DRAM_PIXEL_UNPACKER_FRAME_LOOP_EN
      state_d = REQ;
      addr_d = DRAM_ADDR_BASE;
      beat_d = '0;
      groups_d = groups_of(len_q);
      pixels_d = len_q;
`else
      busy_d = 1'b0;
`endif
    end
  end
  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= DRAM_ADDR_BASE;
      beat_q <= '0;
      groups_q <= '0;
      pixels_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      en_q <= 1'b0;
`ifdef DRAM_PIXEL_UNPACKER_FRAME_LOOP_EN
      len_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      beat_q <= beat_d;
      groups_q <= groups_d;
      pixels_q <= pixels_d;
      busy_q <= busy_d;
      done_q <= done_d;
      en_q <= en_d;
`ifdef DRAM_PIXEL_UNPACKER_FRAME_LOOP_EN
      len_q <= len_d;
`endif
    end
  end
  pixel_group_unpacker u_unpack (
    .m_axi_aclk(m_axi_aclk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_slot(beat_q),
    .wr_data(dram_read_data),
    .wr_full(wr_full),
    .last_pix(pixels_q == FRAME_LEN_WIDTH'(1)),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_last(pix_last),
    .pix_fire(pix_fire)
  );
endmodule

// File: tb/tb_dram_pixel_unpacker.sv
// tb_dram_pixel_unpacker: scoreboard bench with a fixed-latency DRAM responder
module tb_dram_pixel_unpacker;
  localparam logic [38:0] BASE = 39'h400000000;
  localparam int LAT = 5;
  logic m_axi_aclk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [23:0] frame_len = '0;
  logic busy, done, dram_read_en, pix_valid, pix_last;
  logic [38:0] dram_read_addr;
  logic [7:0] dram_read_len;
  logic dram_read_busy = 1'b0;
  logic [511:0] dram_read_data = '0;
  logic dram_read_valid = 1'b0;
  logic [23:0] pix_data;
  logic pix_ready = 1'b1;
  int n_checks = 0, n_fail = 0, rd_cnt = 0, pix_cnt = 0, done_cnt = 0, resp_cnt = 0;
  logic [38:0] resp_addr = '0;
  logic rnd = 1'b0, prev_stall = 1'b0, prev_lastfire = 1'b0;
  logic [23:0] prev_data = '0;
  logic [23:0] exp_pix [$];
  logic exp_last [$];
  logic [38:0] exp_addr [$];
  always #5 m_axi_aclk = ~m_axi_aclk;
  dram_pixel_unpacker dut (
    .m_axi_aclk(m_axi_aclk),
    .reset(reset),
    .start(start),
    .frame_len(frame_len),
    .busy(busy),
    .done(done),
    .dram_read_en(dram_read_en),
    .dram_read_addr(dram_read_addr),
    .dram_read_len(dram_read_len),
    .dram_read_busy(dram_read_busy),
    .dram_read_data(dram_read_data),
    .dram_read_valid(dram_read_valid),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_last(pix_last)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [511:0] beat(input logic [38:0] a);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = a[31:0] * 32'h9E3779B1 + 32'(i) * 32'h01234567;
    return r;
  endfunction
  function automatic logic [23:0] pixel(input int k);
    logic [1535:0] g;
    int gi;
    gi = k / 64;
    for (int b = 0; b < 3; b++) g[512*b +: 512] = beat(BASE + 39'(192 * gi + 64 * b));
    return g[24*(k%64) +: 24];
  endfunction
  task automatic tick;
    @(posedge m_axi_aclk);
    #1;
  endtask
  task automatic start_frame(input int len);
    for (int k = 0; k < len; k++) begin
      exp_pix.push_back(pixel(k));
      exp_last.push_back(k == len - 1);
    end
    for (int g = 0; g < (len + 63) / 64; g++)
      for (int b = 0; b < 3; b++) exp_addr.push_back(BASE + 39'(192 * g + 64 * b));
    tick;
    frame_len = 24'(len);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic wait_done(input int max);
    int d0 = done_cnt;
    int c = 0;
    while (done_cnt == d0 && c < max) begin
      tick;
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      c++;
    end
    pix_ready = 1'b1;
    repeat (4) tick;
    check("done_count", 64'(done_cnt - d0), 1);
    check("busy_end", busy, 0);
    check("pix_left", exp_pix.size(), 0);
    check("addr_left", exp_addr.size(), 0);
    exp_pix.delete();
    exp_last.delete();
    exp_addr.delete();
  endtask
  task automatic reset_vals;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", dram_read_en, 0);
    check("rst_addr", dram_read_addr, BASE);
    check("rst_len", dram_read_len, 0);
    check("rst_pvalid", pix_valid, 0);
    check("rst_pdata", pix_data, 0);
    check("rst_plast", pix_last, 0);
  endtask
  initial forever begin
    @(negedge m_axi_aclk);
    dram_read_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        dram_read_valid = 1'b1;
        dram_read_data = beat(resp_addr);
      end
    end
    if (dram_read_en) begin
      resp_addr = dram_read_addr;
      resp_cnt = LAT;
    end
  end
  always @(negedge m_axi_aclk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_lastfire = 1'b0;
    end else begin
      if (dram_read_en) begin
        rd_cnt++;
        if (exp_addr.size() == 0) check("rd_extra", 1, 0);
        else check("rd_addr", dram_read_addr, exp_addr.pop_front());
        check("rd_len", dram_read_len, 0);
      end
      if (done) done_cnt++;
      if (prev_lastfire) begin
        check("done_pulse", done, 1);
        check("busy_drop", busy, 0);
      end
      if (prev_stall) check("pix_hold", {pix_valid, pix_data}, {1'b1, prev_data});
      if (pix_valid && pix_ready) begin
        pix_cnt++;
        if (exp_pix.size() == 0) check("pix_extra", 1, 0);
        else begin
          check("pix_data", pix_data, exp_pix.pop_front());
          check("pix_last", pix_last, exp_last.pop_front());
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_lastfire = pix_valid && pix_ready && pix_last;
      prev_data = pix_data;
    end
  end
  initial begin
    int r0, p0, c;
    repeat (3) tick;
    reset_vals();
    reset = 1'b0;
    r0 = rd_cnt;
    start_frame(64);
    wait_done(2000);
    check("reads_64", 64'(rd_cnt - r0), 3);
    r0 = rd_cnt;
    p0 = pix_cnt;
    start_frame(100);
    wait_done(3000);
    check("reads_100", 64'(rd_cnt - r0), 6);
    check("pix_100", 64'(pix_cnt - p0), 100);
    r0 = rd_cnt;
    p0 = pix_cnt;
    pix_ready = 1'b0;
    start_frame(256);
    repeat (60) tick;
    check("fetch_stall", 64'(rd_cnt - r0), 6);
    rnd = 1'b1;
    wait_done(6000);
    rnd = 1'b0;
    check("reads_256", 64'(rd_cnt - r0), 12);
    check("pix_256", 64'(pix_cnt - p0), 256);
    r0 = rd_cnt;
    dram_read_busy = 1'b1;
    start_frame(64);
    repeat (20) tick;
    check("rd_blocked", 64'(rd_cnt - r0), 0);
    dram_read_busy = 1'b0;
    repeat (3) tick;
    check("rd_released", 64'(rd_cnt - r0), 1);
    wait_done(2000);
    r0 = rd_cnt;
    start_frame(128);
    c = 0;
    while (rd_cnt < r0 + 5 && c < 300) begin
      tick;
      c++;
    end
    check("rst_reach", 64'(rd_cnt - r0), 5);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    reset_vals();
    exp_pix.delete();
    exp_last.delete();
    exp_addr.delete();
    r0 = rd_cnt;
    p0 = pix_cnt;
    repeat (8) tick;
    check("rst_no_rd", 64'(rd_cnt - r0), 0);
    check("rst_no_pix", 64'(pix_cnt - p0), 0);
    check("rst_idle_addr", dram_read_addr, BASE);
    check("rst_idle_pv", pix_valid, 0);
    start_frame(64);
    wait_done(2000);
    check("reads_after_rst", 64'(rd_cnt - r0), 3);
    r0 = rd_cnt;
    p0 = pix_cnt;
    start_frame(0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    tick;
    check("zero_done_once", done, 0);
    repeat (10) tick;
    check("zero_no_rd", 64'(rd_cnt - r0), 0);
    check("zero_no_pix", 64'(pix_cnt - p0), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
